// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address I2C responder. Writes are delivered on rx_data_o/rx_valid_o,
// reads return tx_data_i. There is no clock stretching and sda is only ever pulled low.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter
// after each synchronizer.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
  input  logic       i2c_core_clk_i,
  input  logic       preset_ni,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ack_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_DATA   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_DATA   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;
  logic       r_scl_q;
  logic       r_sda_q;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [6:0] r_tx_shift;
  logic       r_byte_done;
  logic       r_rw;
  logic       r_mack;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_ack;
  logic       r_busy;

  // Two-flop synchronizers, preset high so reset never fakes a START.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] r_scl_flt;
  logic [2:0] r_sda_flt;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Three-sample history of each synchronized line for majority voting.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_scl_flt <= 3'b111;
      r_sda_flt <= 3'b111;
    end else begin
      r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[1]};
      r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[1]};
    end
  end

  assign w_scl = maj3(r_scl_flt);
  assign w_sda = maj3(r_sda_flt);
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous-cycle copies of the cleaned lines for edge and condition detection.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = w_scl & r_scl_q & ~w_sda & r_sda_q;
  assign w_stop     = w_scl & r_scl_q & w_sda & ~r_sda_q;

  // Protocol FSM: samples on scl rise, changes sda only on scl fall.
  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_tx_shift  <= 7'h00;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;
      if (w_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        r_sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state     <= ST_IDLE;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_rw     <= r_shift[0];
                r_busy   <= 1'b1;
                r_sda_oe <= 1'b1;
                r_state  <= ST_ADDR_ACK;
              end else begin
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 3'd0;
              if (r_rw) begin
                r_tx_shift <= tx_data_i[6:0];
                r_tx_ack   <= 1'b1;
                r_sda_oe   <= ~tx_data_i[7];
                r_state    <= ST_TX_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_RX_DATA;
              end
            end
          end
          ST_RX_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (rx_ready_i) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_sda_oe   <= 1'b1;
                r_state    <= ST_RX_ACK;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          ST_RX_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 3'd0;
              r_sda_oe  <= 1'b0;
              r_state   <= ST_RX_DATA;
            end
          end
          ST_TX_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                r_sda_oe    <= 1'b0;
                r_byte_done <= 1'b0;
                r_state     <= ST_TX_ACK;
              end else begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              end
            end
          end
          ST_TX_ACK: begin
            if (w_scl_rise) begin
              r_mack      <= w_sda;
              r_byte_done <= 1'b1;
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_bit_cnt   <= 3'd0;
              if (!r_mack) begin
                r_tx_shift <= tx_data_i[6:0];
                r_tx_ack   <= 1'b1;
                r_sda_oe   <= ~tx_data_i[7];
                r_state    <= ST_TX_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda        = r_sda_oe ? 1'b0 : 1'bz;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign tx_ack_o   = r_tx_ack;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged I2C initiator with a scoreboard of
// expected received/returned bytes.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int T = 16;  // half scl period in core clocks

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sda_w;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int rx_cnt    = 0;
  int txack_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_slave #(.SLAVE_ADDR(7'h10)) dut (
    .i2c_core_clk_i(clk),
    .preset_ni     (rst_n),
    .scl           (m_scl),
    .sda           (sda_w),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .tx_data_i     (tx_data),
    .tx_ack_o      (tx_ack),
    .busy_o        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each rx_valid cycle and counts pulses.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rx_cnt++;
      if (rx_q.size() > 0) check_eq("rx_byte", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      else check_eq("rx_spurious", 32'd1, 32'd0);
    end
    if (rst_n && tx_ack) txack_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_clk(T);
    m_scl = 1'b1;     wait_clk(T);
    m_sda_low = 1'b1; wait_clk(T);
    m_scl = 1'b0;     wait_clk(T);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clk(T);
    m_scl = 1'b1;     wait_clk(T);
    m_sda_low = 1'b0; wait_clk(T);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda_low = ~b; wait_clk(T);
    m_scl = 1'b1;   wait_clk(T / 2);
    s = sda_w;      wait_clk(T / 2);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  task automatic send_ack(input logic b);
    logic s;
    clock_bit(b, s);
  endtask

  task automatic check_tx(input logic [7:0] got);
    if (tx_q.size() > 0) check_eq("tx_byte", {24'h0, got}, {24'h0, tx_q.pop_front()});
    else check_eq("tx_underflow", 32'd1, 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx0;
    int         tx0;
    rst_n = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0; rx_ready = 1'b1; tx_data = 8'h00;
    wait_clk(5);
    check_eq("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check_eq("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check_eq("rst_tx_ack", {31'h0, tx_ack}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_sda", {31'h0, sda_w}, 32'h1);
    rst_n = 1'b1;
    wait_clk(10);

    // Write 8'h12 to the matching address.
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h20, ack);
    check_eq("wr_addr_ack", {31'h0, ack}, 32'h0);
    check_eq("wr_busy", {31'h0, busy}, 32'h1);
    rx_q.push_back(8'h12);
    send_byte(8'h12, ack);
    check_eq("wr_data_ack", {31'h0, ack}, 32'h0);
    bus_stop();
    wait_clk(4);
    check_eq("wr_busy_after_stop", {31'h0, busy}, 32'h0);
    check_eq("wr_rx_pulses", rx_cnt - rx0, 32'd1);

    // Read two bytes, ACK then NACK.
    tx0 = txack_cnt;
    tx_data = 8'hA3;
    tx_q.push_back(8'hA3);
    bus_start();
    send_byte(8'h21, ack);
    check_eq("rd_addr_ack", {31'h0, ack}, 32'h0);
    read_byte(d);
    check_tx(d);
    tx_data = 8'h11;
    tx_q.push_back(8'h11);
    send_ack(1'b0);
    read_byte(d);
    check_tx(d);
    send_ack(1'b1);
    wait_clk(T);
    check_eq("rd_sda_released_after_nack", {31'h0, sda_w}, 32'h1);
    check_eq("rd_tx_ack_pulses", txack_cnt - tx0, 32'd2);
    bus_stop();
    wait_clk(4);
    check_eq("rd_busy_after_stop", {31'h0, busy}, 32'h0);

    // Address mismatch: no ACK, no traffic until the next START.
    rx0 = rx_cnt; tx0 = txack_cnt;
    bus_start();
    send_byte(8'h40, ack);
    check_eq("mis_addr_nack", {31'h0, ack}, 32'h1);
    check_eq("mis_busy", {31'h0, busy}, 32'h0);
    send_byte(8'h12, ack);
    check_eq("mis_data_nack", {31'h0, ack}, 32'h1);
    bus_stop();
    check_eq("mis_rx_pulses", rx_cnt - rx0, 32'd0);
    check_eq("mis_tx_pulses", txack_cnt - tx0, 32'd0);

    // Consumer not ready: byte dropped with NACK, further bytes ignored.
    rx0 = rx_cnt;
    rx_ready = 1'b0;
    bus_start();
    send_byte(8'h20, ack);
    check_eq("nr_addr_ack", {31'h0, ack}, 32'h0);
    send_byte(8'h55, ack);
    check_eq("nr_data_nack", {31'h0, ack}, 32'h1);
    send_byte(8'h66, ack);
    check_eq("nr_wait_stop_nack", {31'h0, ack}, 32'h1);
    bus_stop();
    wait_clk(4);
    check_eq("nr_rx_pulses", rx_cnt - rx0, 32'd0);
    check_eq("nr_busy_after_stop", {31'h0, busy}, 32'h0);
    rx_ready = 1'b1;

    // Write then repeated START into a read.
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h20, ack);
    check_eq("rs_wr_addr_ack", {31'h0, ack}, 32'h0);
    rx_q.push_back(8'h12);
    send_byte(8'h12, ack);
    check_eq("rs_wr_data_ack", {31'h0, ack}, 32'h0);
    tx_data = 8'h3C;
    tx_q.push_back(8'h3C);
    bus_start();
    send_byte(8'h21, ack);
    check_eq("rs_rd_addr_ack", {31'h0, ack}, 32'h0);
    read_byte(d);
    check_tx(d);
    send_ack(1'b1);
    bus_stop();
    check_eq("rs_rx_pulses", rx_cnt - rx0, 32'd1);

    // Reset while driving a 0 data bit.
    tx0 = txack_cnt;
    tx_data = 8'h0F;
    bus_start();
    send_byte(8'h21, ack);
    check_eq("rst_mid_addr_ack", {31'h0, ack}, 32'h0);
    wait_clk(6);
    check_eq("rst_mid_driving_low", {31'h0, sda_w}, 32'h0);
    check_eq("rst_mid_tx_ack_pulse", txack_cnt - tx0, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_sda_released", {31'h0, sda_w}, 32'h1);
    check_eq("rst_mid_rx_data", {24'h0, rx_data}, 32'h0);
    check_eq("rst_mid_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_mid_tx_ack", {31'h0, tx_ack}, 32'h0);
    m_sda_low = 1'b0; m_scl = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);

    // After reset, bus activity without START is ignored.
    m_scl = 1'b0;
    wait_clk(T);
    send_byte(8'h20, ack);
    check_eq("post_rst_no_start_nack", {31'h0, ack}, 32'h1);
    check_eq("post_rst_busy", {31'h0, busy}, 32'h0);
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h20, ack);
    check_eq("post_rst_addr_ack", {31'h0, ack}, 32'h0);
    rx_q.push_back(8'h77);
    send_byte(8'h77, ack);
    check_eq("post_rst_data_ack", {31'h0, ack}, 32'h0);
    bus_stop();
    wait_clk(4);
    check_eq("post_rst_rx_pulses", rx_cnt - rx0, 32'd1);
    check_eq("rx_queue_drained", rx_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
- REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h10, the 7-bit address this responder answers to (write byte 8'h20, read byte 8'h21).
- REQ-002 SHALL have port i2c_core_clk_i, input, 1, the single clock. Rising edge only.
- REQ-003 SHALL have port preset_ni, input, 1, reset. Asynchronous assert, active-low.
- REQ-004 SHALL have port scl, input, 1, I2C clock from the initiator. No clock stretching.
- REQ-005 SHALL have port sda, inout, 1, open-drain data. The block drives it only to 0, otherwise 1'bz.
- REQ-006 SHALL have port rx_data_o, output, 8, last received data byte.
- REQ-007 SHALL have port rx_valid_o, output, 1, one-cycle pulse when rx_data_o updates.
- REQ-008 SHALL have port rx_ready_i, input, 1, consumer can accept a byte.
- REQ-009 SHALL have port tx_data_i, input, 8, byte to return on a read.
- REQ-010 SHALL have port tx_ack_o, output, 1, one-cycle pulse when tx_data_i is latched.
- REQ-011 SHALL have port busy_o, output, 1, high from an address-matched START until STOP or mismatch.

Function
- REQ-012 SHALL pass scl and sda through 2-flop synchronizers and detect edges on the synchronized values.
- REQ-013 SHALL detect START as sda falling while scl is high, and STOP as sda rising while scl is high.
- REQ-014 SHALL use FSM states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- REQ-015 SHALL sample sda on every synchronized scl rising edge, MSB first, using a 3-bit bit counter.
- REQ-016 SHALL change sda only on a synchronized scl falling edge (ADDR/DATA transitions included).
- REQ-017 On START in any state, including a repeated START, SHALL clear the bit counter, release sda and enter ADDR.
- REQ-018 On STOP in any state SHALL release sda, clear busy_o and enter IDLE.
- REQ-019 In ADDR after 8 bits: if addr[7:1]==SLAVE_ADDR SHALL drive ACK (sda=0) for one scl period and go to RX_DATA (R/W=0) or TX_DATA (R/W=1); otherwise SHALL leave sda released (NACK) and go to WAIT_STOP.
- REQ-020 In RX_DATA after the 8th bit with rx_ready_i=1: SHALL update rx_data_o, pulse rx_valid_o exactly one cycle, ACK in RX_ACK, then return to RX_DATA.
- REQ-021 In RX_DATA after the 8th bit with rx_ready_i=0: SHALL drop the byte, give no rx_valid_o pulse, NACK, and go to WAIT_STOP.
- REQ-022 On the scl falling edge that enters TX_DATA: SHALL latch tx_data_i, pulse tx_ack_o one cycle, and drive bit 7 (0 drives low, 1 releases).
- REQ-023 In TX_DATA SHALL shift out the remaining bits on falling edges, then release sda for TX_ACK.
- REQ-024 In TX_ACK SHALL sample the initiator's bit on scl rising: 0 (ACK) returns to TX_DATA and reloads; 1 (NACK) goes to WAIT_STOP with sda released.
- REQ-025 SHALL never drive sda in IDLE or WAIT_STOP.

Reset
- REQ-026 While preset_ni=0: state=IDLE, sda released, rx_data_o=8'h00, rx_valid_o=0, tx_ack_o=0, busy_o=0, counters and shift registers=0, synchronizers preset to 1.
- REQ-027 When reset asserts mid-transfer, SHALL release sda immediately (asynchronously).
- REQ-028 After reset deassert, SHALL ignore bus activity until the next START.

Configuration
- REQ-029 With I2C_SLAVE_GLITCH_FILTER_EN defined: SHALL insert a 3-sample majority filter after each synchronizer, adding 2 cycles of detection latency and rejecting pulses shorter than 2 cycles.
- REQ-030 With I2C_SLAVE_GLITCH_FILTER_EN undefined: SHALL have no filter. Edge detection latency is exactly 2 synchronizer cycles plus 1 detect cycle.

Verification
- REQ-031 START, 8'h20, data 8'h12, STOP with rx_ready_i=1 -> sda=0 in both ACK slots, one rx_valid_o pulse with rx_data_o=8'h12, busy_o=0 after STOP.
- REQ-032 START, 8'h21, tx_data_i=8'hA3 then 8'h11, initiator ACK then NACK -> sda bits 10100011 then 00010001, two tx_ack_o pulses, sda released after NACK.
- REQ-033 START, 8'h40 -> sda stays high in the ACK slot, busy_o=0, no rx_valid_o or tx_ack_o until the next START.
- REQ-034 START, 8'h20, data 8'h55 with rx_ready_i=0 -> NACK, no rx_valid_o, WAIT_STOP until STOP.
- REQ-035 START, 8'h20, 8'h12, repeated START, 8'h21 -> ADDR re-entered, second ACK given, TX_DATA drives tx_data_i.
- REQ-036 preset_ni pulled low during TX_DATA while driving 0 -> sda released in the same cycle, all outputs at reset values.
